// File: rtl/hazard_mc.sv
// Pipeline hazard unit: forwarding, load-use, multi-cycle divide and memory-wait stalls, branch flush.
// Controls are combinational from the current stage contents; div_cnt and the perf counters are registered.
module hazard_mc #(
  parameter int REG_AW      = 5,
  parameter int DIV_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              ResultSrcE_zero,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MulDivE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              DivBusy,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam int DCW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_LATENCY - 1);

  logic [DCW-1:0] div_cnt;
  logic           memstall;
  logic           divstall;
  logic           lwstall;

  assign memstall = MemReqM && !MemReadyM;
  assign divstall = MulDivE && (div_cnt != DIV_LAST);
  assign lwstall  = ResultSrcE_zero && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign DivBusy  = divstall && !memstall && !reset;

  // M has priority over W: it holds the younger value of the register
  always_comb begin
    ForwardAE = 2'b00;
    if ((Rs1E != '0) && (Rs1E == RdM) && RegWriteM)      ForwardAE = 2'b10;
    else if ((Rs1E != '0) && (Rs1E == RdW) && RegWriteW) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if ((Rs2E != '0) && (Rs2E == RdM) && RegWriteM)      ForwardBE = 2'b10;
    else if ((Rs2E != '0) && (Rs2E == RdW) && RegWriteW) ForwardBE = 2'b01;
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else if (memstall) begin
      // a taken branch stays parked in E and flushes once the access completes
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (divstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (lwstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
      FlushD = PCSrcE;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !MulDivE) begin
      div_cnt <= '0;
    end else if (!memstall) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != '1))             StallCount <= StallCount + 1'b1;
      if ((FlushD || FlushE) && (FlushCount != '1)) FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_mc.sv
// Bench for hazard_mc: expected control vectors are queued as each cycle is driven
// and compared at the following falling edge; counters are checked after the counting edge.
module tb_hazard_mc;

  logic       clk = 1'b1;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, MulDivE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, DivBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] StallCount, FlushCount;

  logic       s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushM, s_FlushW, s_DivBusy;
  logic [1:0] s_ForwardAE, s_ForwardBE;
  logic [3:0] s_StallCount, s_FlushCount;

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  hazard_mc #(.REG_AW(5), .DIV_LATENCY(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE_zero(ResultSrcE_zero), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MulDivE(MulDivE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .DivBusy(DivBusy),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  hazard_mc #(.REG_AW(5), .DIV_LATENCY(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE_zero(ResultSrcE_zero), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MulDivE(MulDivE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
    .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushM(s_FlushM), .FlushW(s_FlushW),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .DivBusy(s_DivBusy),
    .StallCount(s_StallCount), .FlushCount(s_FlushCount)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ctl bit order: {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushM,FlushW, DivBusy}
  localparam logic [8:0] C_NONE = 9'b0000_0000_0;
  localparam logic [8:0] C_RST  = 9'b0000_1111_0;
  localparam logic [8:0] C_LW   = 9'b1100_0100_0;
  localparam logic [8:0] C_LWBR = 9'b1100_1100_0;
  localparam logic [8:0] C_DIV  = 9'b1110_0010_1;
  localparam logic [8:0] C_MEM  = 9'b1111_0001_0;
  localparam logic [8:0] C_BR   = 9'b0000_1100_0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
              FlushD, FlushE, FlushM, FlushW, DivBusy}, e);
    end
  end

  task automatic cyc(input string tag, input logic [1:0] fa, input logic [1:0] fb, input logic [8:0] ctl);
    exp_q.push_back({fa, fb, ctl});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE_zero = 0; RegWriteM = 0; RegWriteW = 0;
    PCSrcE = 0; MulDivE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cyc("reset", 2'b00, 2'b00, C_RST);
    reset = 0;
    chk("rst_stallcnt", 64'(StallCount), 64'd0);
    chk("rst_flushcnt", 64'(FlushCount), 64'd0);
  endtask

  initial begin
    idle();
    reset = 1;
    cyc("reset0", 2'b00, 2'b00, C_RST);
    cyc("reset1", 2'b00, 2'b00, C_RST);
    chk("init_stallcnt", 64'(StallCount), 64'd0);
    chk("init_flushcnt", 64'(FlushCount), 64'd0);

    // forwarding
    idle();
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
    cyc("fwd_m", 2'b10, 2'b00, C_NONE);
    RegWriteM = 0;
    cyc("fwd_w", 2'b01, 2'b00, C_NONE);
    RegWriteM = 1; RegWriteW = 0; Rs1E = 6; Rs2E = 5;
    cyc("fwd_b_m", 2'b00, 2'b10, C_NONE);
    RdM = 0; RdW = 0; RegWriteW = 1; Rs1E = 0; Rs2E = 0;
    cyc("fwd_x0", 2'b00, 2'b00, C_NONE);

    // load-use
    idle();
    ResultSrcE_zero = 1; RdE = 7; Rs2D = 7;
    cyc("lw", 2'b00, 2'b00, C_LW);
    chk("lw_stallcnt", 64'(StallCount), 64'd1);
    RdE = 0; Rs2D = 0;
    cyc("lw_x0", 2'b00, 2'b00, C_NONE);
    RdE = 9; Rs1D = 9; PCSrcE = 1;
    cyc("lw_br", 2'b00, 2'b00, C_LWBR);
    idle();
    cyc("lw_idle", 2'b00, 2'b00, C_NONE);
    chk("lw_stallcnt2", 64'(StallCount), 64'd2);
    chk("lw_flushcnt", 64'(FlushCount), 64'd2);

    // divide, 3 stall cycles then release
    do_reset();
    MulDivE = 1;
    for (int i = 0; i < 3; i++) cyc($sformatf("div_%0d", i), 2'b00, 2'b00, C_DIV);
    cyc("div_done", 2'b00, 2'b00, C_NONE);
    idle();
    cyc("div_idle", 2'b00, 2'b00, C_NONE);
    chk("div_stallcnt", 64'(StallCount), 64'd3);
    chk("div_flushcnt", 64'(FlushCount), 64'd0);

    // memory wait landing on divide cycle 2
    do_reset();
    MulDivE = 1;
    cyc("dm_div0", 2'b00, 2'b00, C_DIV);
    cyc("dm_div1", 2'b00, 2'b00, C_DIV);
    MemReqM = 1; MemReadyM = 0;
    cyc("dm_mem0", 2'b00, 2'b00, C_MEM);
    cyc("dm_mem1", 2'b00, 2'b00, C_MEM);
    MemReqM = 0;
    cyc("dm_div2", 2'b00, 2'b00, C_DIV);
    cyc("dm_done", 2'b00, 2'b00, C_NONE);
    idle();
    cyc("dm_idle", 2'b00, 2'b00, C_NONE);
    chk("dm_stallcnt", 64'(StallCount), 64'd5);

    // taken branch held behind a memory wait
    do_reset();
    PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
    cyc("bm_wait0", 2'b00, 2'b00, C_MEM);
    cyc("bm_wait1", 2'b00, 2'b00, C_MEM);
    MemReadyM = 1;
    cyc("bm_ready", 2'b00, 2'b00, C_BR);
    idle();
    MemReadyM = 1;
    cyc("rdy_noreq", 2'b00, 2'b00, C_NONE);
    chk("bm_flushcnt", 64'(FlushCount), 64'd1);
    chk("bm_stallcnt", 64'(StallCount), 64'd2);

    // reset in the middle of a divide
    do_reset();
    MulDivE = 1;
    cyc("rd_div0", 2'b00, 2'b00, C_DIV);
    cyc("rd_div1", 2'b00, 2'b00, C_DIV);
    reset = 1;
    cyc("rd_reset", 2'b00, 2'b00, C_RST);
    reset = 0;
    chk("rd_stallcnt0", 64'(StallCount), 64'd0);
    chk("rd_flushcnt0", 64'(FlushCount), 64'd0);
    for (int i = 0; i < 3; i++) cyc($sformatf("rd_div_%0d", i), 2'b00, 2'b00, C_DIV);
    cyc("rd_done", 2'b00, 2'b00, C_NONE);
    idle();
    chk("rd_stallcnt", 64'(StallCount), 64'd3);

    // saturation on the 4-bit counter instance
    do_reset();
    ResultSrcE_zero = 1; RdE = 3; Rs1D = 3;
    for (int i = 0; i < 20; i++) cyc($sformatf("sat_%0d", i), 2'b00, 2'b00, C_LW);
    idle();
    chk("sat_stallcnt", 64'(s_StallCount), 64'd15);
    chk("sat_flushcnt", 64'(s_FlushCount), 64'd15);
    chk("wide_stallcnt", 64'(StallCount), 64'd20);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
